outport_switch_alloc: RTL and testbench

- Per-output-port switch allocation and traversal stage. It sits directly downstream of the per-outport priority resolver.
- It consumes the resolver's isNew/firstPriority winner and locks the output to that inport for a whole wormhole packet.
- It gates forwarding on downstream credits, pops the granted inport, and drives a registered output flit toward the link/next router.

---
 rtl/outport_switch_alloc_pkg.sv | 41 ++++
 rtl/outport_switch_alloc_credit_counter.sv | 43 ++++
 rtl/outport_switch_alloc.sv | 176 +++++++++++++++++
 tb/tb_outport_switch_alloc.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/outport_switch_alloc_pkg.sv
// ----------------------------------------------------------------------------
// outport_switch_alloc_pkg
// Shared constants and types for the per-outport switch allocator:
//   - default sizing (ports, flit width, downstream credits)
//   - flit type codes and the position of the type field inside a flit
//   - allocator FSM state encoding
// No ports (package).
// ----------------------------------------------------------------------------
package outport_switch_alloc_pkg;

    localparam int DEFAULT_PORTS   = 7;
    localparam int DEFAULT_FLIT_W  = 32;
    localparam int DEFAULT_CREDITS = 4;
    localparam int DEFAULT_CRED_W  = 3;
    localparam int LOG_PORTS_CNT   = 3;

    // Flit type lives in flit bits [0:1] (bit 0 is the leftmost/MSB bit).
    localparam int FLIT_TYPE_POS = 0;
    localparam int FLIT_TYPE_W   = 2;

    localparam logic [1:0] FLIT_TYPE_HEADTAIL = 2'b00;
    localparam logic [1:0] FLIT_TYPE_HEAD     = 2'b01;
    localparam logic [1:0] FLIT_TYPE_BODY     = 2'b10;
    localparam logic [1:0] FLIT_TYPE_TAIL     = 2'b11;

    typedef enum logic {
        ALLOC_IDLE   = 1'b0,
        ALLOC_LOCKED = 1'b1
    } alloc_state_t;

    // A packet may only start with a HEAD or a single-flit HEADTAIL.
    function automatic logic is_start_type(input logic [1:0] t);
        return (t == FLIT_TYPE_HEAD) || (t == FLIT_TYPE_HEADTAIL);
    endfunction

    // TAIL and HEADTAIL both close a packet.
    function automatic logic is_end_type(input logic [1:0] t);
        return (t == FLIT_TYPE_TAIL) || (t == FLIT_TYPE_HEADTAIL);
    endfunction

endpackage

// File: rtl/outport_switch_alloc_credit_counter.sv
// ----------------------------------------------------------------------------
// outport_credit_counter
// Up/down saturating counter of downstream buffer slots.
//   clk, rst     : clock, async active-high reset (loads CREDITS)
//   inc          : downstream returned one slot (ignored when already full)
//   dec          : a flit was forwarded (only issued when nonzero)
//   credit_cnt   : available credits
//   nonzero      : credit_cnt != 0, used to gate forwarding
// ----------------------------------------------------------------------------
module outport_credit_counter
    import outport_switch_alloc_pkg::*;
#(
    parameter int CREDITS = DEFAULT_CREDITS,
    parameter int CRED_W  = DEFAULT_CRED_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc,
    input  logic              dec,
    output logic [CRED_W-1:0] credit_cnt,
    output logic              nonzero
);

    localparam logic [CRED_W-1:0] MAX_CNT = CRED_W'(CREDITS);

    logic at_max;

    assign at_max  = (credit_cnt == MAX_CNT);
    assign nonzero = (credit_cnt != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credit_cnt <= MAX_CNT;
        end else begin
            case ({inc, dec})
                2'b10: if (!at_max) credit_cnt <= credit_cnt + 1'b1;
                2'b01: if (nonzero) credit_cnt <= credit_cnt - 1'b1;
                default: ; // idle, or return and consume cancel out
            endcase
        end
    end

endmodule

// File: rtl/outport_switch_alloc.sv
// ----------------------------------------------------------------------------
// outport_switch_alloc
// Per-outport switch allocation and traversal. Takes the priority resolver's
// winner, locks the outport to that inport for a whole wormhole packet, gates
// forwarding on downstream credits, pops the granted inport and registers the
// forwarded flit.
//
// Ports:
//   clk, rst        : clock, async active-high reset
//   isNew           : resolver has a new head flit for this outport
//   firstPriority   : resolver winner inport id
//   flit_in         : head-of-queue flits, inport i at [i*FLIT_W +: FLIT_W]
//   flit_valid      : per-inport head-of-queue valid, [0:PORTS-1]
//   credit_in       : one-cycle pulse, downstream freed a slot
//   pop             : one-hot combinational dequeue strobe, [0:PORTS-1]
//   out_flit        : registered forwarded flit
//   out_valid       : out_flit valid this cycle
//   locked          : outport owned by a packet
//   owner           : owning inport (0 when not locked)
//   credit_cnt      : available downstream credits
//   pkt_count       : (OUTPORT_ALLOC_STATS_EN) packets forwarded, wraps
//   credit_err      : (OUTPORT_ALLOC_STATS_EN) sticky credit overflow flag
//
// Optional feature macro: OUTPORT_ALLOC_STATS_EN adds pkt_count/credit_err.
//
// FSM states:
//   ALLOC_IDLE   | no packet owns the outport; resolver winner may start one
//   ALLOC_LOCKED | outport owned by `owner` until its TAIL is forwarded
// ----------------------------------------------------------------------------
module outport_switch_alloc
    import outport_switch_alloc_pkg::*;
#(
    parameter int PORTS   = DEFAULT_PORTS,
    parameter int FLIT_W  = DEFAULT_FLIT_W,
    parameter int CREDITS = DEFAULT_CREDITS,
    parameter int CRED_W  = DEFAULT_CRED_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     isNew,
    input  logic [LOG_PORTS_CNT-1:0] firstPriority,
    input  logic [0:PORTS*FLIT_W-1]  flit_in,
    input  logic [0:PORTS-1]         flit_valid,
    input  logic                     credit_in,
    output logic [0:PORTS-1]         pop,
    output logic [0:FLIT_W-1]        out_flit,
    output logic                     out_valid,
    output logic                     locked,
    output logic [LOG_PORTS_CNT-1:0] owner,
    output logic [CRED_W-1:0]        credit_cnt
`ifdef OUTPORT_ALLOC_STATS_EN
    ,
    output logic [15:0]              pkt_count,
    output logic                     credit_err
`endif
);

    localparam int SEL_W = LOG_PORTS_CNT;

    alloc_state_t     state_q, state_d;
    logic [SEL_W-1:0] owner_q, owner_d;
    logic [SEL_W-1:0] sel;
    logic             sel_valid;
    logic [0:FLIT_W-1] sel_flit;
    logic [1:0]       sel_type;
    logic             fp_in_range;
    logic             send;
    logic             credit_nonzero;

    outport_credit_counter #(
        .CREDITS (CREDITS),
        .CRED_W  (CRED_W)
    ) u_credit (
        .clk        (clk),
        .rst        (rst),
        .inc        (credit_in),
        .dec        (send),
        .credit_cnt (credit_cnt),
        .nonzero    (credit_nonzero)
    );

    // While locked the resolver is ignored and the owner is the only candidate.
    assign sel = (state_q == ALLOC_LOCKED) ? owner_q : firstPriority;

    // Widened compare so the range check stays correct if PORTS == 2**SEL_W.
    assign fp_in_range = ({1'b0, firstPriority} < (SEL_W + 1)'(PORTS));

    // Mux out the selected inport; ids beyond PORTS select nothing.
    always_comb begin
        sel_valid = 1'b0;
        sel_flit  = '0;
        for (int i = 0; i < PORTS; i++) begin
            if (sel == SEL_W'(i)) begin
                sel_valid = flit_valid[i];
                sel_flit  = flit_in[i*FLIT_W +: FLIT_W];
            end
        end
    end

    assign sel_type = sel_flit[FLIT_TYPE_POS +: FLIT_TYPE_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ALLOC_IDLE;
            owner_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end

    // rst gates send so no inport is popped while the stage is held in reset.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        send    = 1'b0;
        case (state_q)
            ALLOC_IDLE: begin
                if (!rst && isNew && fp_in_range && sel_valid &&
                    is_start_type(sel_type) && credit_nonzero) begin
                    send = 1'b1;
                    if (sel_type == FLIT_TYPE_HEAD) begin
                        state_d = ALLOC_LOCKED;
                        owner_d = firstPriority;
                    end
                end
            end
            ALLOC_LOCKED: begin
                if (!rst && sel_valid && credit_nonzero) begin
                    send = 1'b1;
                    if (sel_type == FLIT_TYPE_TAIL) begin
                        state_d = ALLOC_IDLE;
                        owner_d = '0;
                    end
                end
            end
            default: begin
                state_d = ALLOC_IDLE;
                owner_d = '0;
            end
        endcase
    end

    always_comb begin
        pop = '0;
        for (int i = 0; i < PORTS; i++) begin
            pop[i] = send && (sel == SEL_W'(i));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_flit  <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= send;
            if (send) out_flit <= sel_flit;
        end
    end

    assign locked = (state_q == ALLOC_LOCKED);
    assign owner  = owner_q;

`ifdef OUTPORT_ALLOC_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_count  <= '0;
            credit_err <= 1'b0;
        end else begin
            if (send && is_end_type(sel_type)) pkt_count <= pkt_count + 16'd1;
            if (credit_in && (credit_cnt == CRED_W'(CREDITS))) credit_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_outport_switch_alloc.sv
module tb_outport_switch_alloc;

    localparam int P  = 7;
    localparam int FW = 32;

    logic            clk;
    logic            rst;
    logic            isNew;
    logic [2:0]      firstPriority;
    logic [0:P*FW-1] flit_in;
    logic [0:P-1]    flit_valid;
    logic            credit_in;
    logic [0:P-1]    pop;
    logic [0:FW-1]   out_flit;
    logic            out_valid;
    logic            locked;
    logic [2:0]      owner;
    logic [2:0]      credit_cnt;
`ifdef OUTPORT_ALLOC_STATS_EN
    logic [15:0]     pkt_count;
    logic            credit_err;
`endif

    int total  = 0;
    int passed = 0;

    outport_switch_alloc dut (
        .clk           (clk),
        .rst           (rst),
        .isNew         (isNew),
        .firstPriority (firstPriority),
        .flit_in       (flit_in),
        .flit_valid    (flit_valid),
        .credit_in     (credit_in),
        .pop           (pop),
        .out_flit      (out_flit),
        .out_valid     (out_valid),
        .locked        (locked),
        .owner         (owner),
        .credit_cnt    (credit_cnt)
`ifdef OUTPORT_ALLOC_STATS_EN
        ,
        .pkt_count     (pkt_count),
        .credit_err    (credit_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    task automatic clear_inputs();
        isNew         = 1'b0;
        firstPriority = 3'd0;
        flit_in       = '0;
        flit_valid    = '0;
        credit_in     = 1'b0;
    endtask

    task automatic put_flit(input int i, input logic [0:FW-1] v);
        flit_in[i*FW +: FW] = v;
        flit_valid[i]       = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        put_flit(0, 32'h4000_0000);
        isNew = 1'b1;
        step();
        total++; if (pop !== 7'b0) $display("FAIL rst_pop got=%b exp=%b", pop, 7'b0); else passed++;
        step();
        total++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid got=%b exp=0", out_valid); else passed++;
        total++; if (credit_cnt !== 3'd4) $display("FAIL rst_credit got=%0d exp=4", credit_cnt); else passed++;
        total++; if (locked !== 1'b0) $display("FAIL rst_locked got=%b exp=0", locked); else passed++;
        total++; if (owner !== 3'd0) $display("FAIL rst_owner got=%0d exp=0", owner); else passed++;
        total++; if (out_flit !== 32'h0) $display("FAIL rst_out_flit got=%h exp=0", out_flit); else passed++;
`ifdef OUTPORT_ALLOC_STATS_EN
        total++; if (pkt_count !== 16'd0) $display("FAIL rst_pkt_count got=%0d exp=0", pkt_count); else passed++;
`endif
        clear_inputs();
        rst = 1'b0;
        #1;
        total++; if (pop !== 7'b0) $display("FAIL idle_pop got=%b exp=0", pop); else passed++;
        step();
        total++; if (credit_cnt !== 3'd4) $display("FAIL idle_credit got=%0d exp=4", credit_cnt); else passed++;
    endtask

    // 3-flit packet on inport 2 while inport 5 waits with a HEAD.
    task automatic test_packet_lock();
        clear_inputs();
        isNew = 1'b1; firstPriority = 3'd2;
        put_flit(2, 32'h4000_0002);
        put_flit(5, 32'h4000_0005);
        #1;
        total++; if (pop !== 7'b0010000) $display("FAIL pkt_pop_head got=%b exp=0010000", pop); else passed++;
        step();
        total++; if (out_valid !== 1'b1 || out_flit !== 32'h4000_0002) $display("FAIL pkt_out_head got=%b/%h exp=1/40000002", out_valid, out_flit); else passed++;
        total++; if (locked !== 1'b1 || owner !== 3'd2) $display("FAIL pkt_lock_head got=%b/%0d exp=1/2", locked, owner); else passed++;
        total++; if (credit_cnt !== 3'd3) $display("FAIL pkt_credit_head got=%0d exp=3", credit_cnt); else passed++;

        put_flit(2, 32'h8000_0002);
        firstPriority = 3'd5;
        #1;
        total++; if (pop !== 7'b0010000) $display("FAIL pkt_pop_body got=%b exp=0010000", pop); else passed++;
        step();
        total++; if (out_valid !== 1'b1 || out_flit !== 32'h8000_0002) $display("FAIL pkt_out_body got=%b/%h exp=1/80000002", out_valid, out_flit); else passed++;
        total++; if (locked !== 1'b1 || credit_cnt !== 3'd2) $display("FAIL pkt_state_body got=%b/%0d exp=1/2", locked, credit_cnt); else passed++;

        put_flit(2, 32'hC000_0002);
        #1;
        total++; if (pop !== 7'b0010000) $display("FAIL pkt_pop_tail got=%b exp=0010000", pop); else passed++;
        step();
        total++; if (out_valid !== 1'b1 || out_flit !== 32'hC000_0002) $display("FAIL pkt_out_tail got=%b/%h exp=1/c0000002", out_valid, out_flit); else passed++;
        total++; if (locked !== 1'b0 || owner !== 3'd0) $display("FAIL pkt_unlock got=%b/%0d exp=0/0", locked, owner); else passed++;
        total++; if (credit_cnt !== 3'd1) $display("FAIL pkt_credit_tail got=%0d exp=1", credit_cnt); else passed++;

        flit_valid[2] = 1'b0;
        #1;
        total++; if (pop !== 7'b0000010) $display("FAIL lock_next_pop got=%b exp=0000010", pop); else passed++;
        step();
        total++; if (out_flit !== 32'h4000_0005 || locked !== 1'b1 || owner !== 3'd5) $display("FAIL lock_next_grant got=%h/%b/%0d exp=40000005/1/5", out_flit, locked, owner); else passed++;
        total++; if (credit_cnt !== 3'd0) $display("FAIL lock_next_credit got=%0d exp=0", credit_cnt); else passed++;

        // Zero credits: no send; the returning credit is usable only next cycle.
        put_flit(5, 32'hC000_0005);
        isNew = 1'b0;
        credit_in = 1'b1;
        #1;
        total++; if (pop !== 7'b0) $display("FAIL nobypass_pop got=%b exp=0", pop); else passed++;
        step();
        total++; if (out_valid !== 1'b0 || out_flit !== 32'h4000_0005) $display("FAIL nobypass_out got=%b/%h exp=0/40000005", out_valid, out_flit); else passed++;
        total++; if (credit_cnt !== 3'd1 || locked !== 1'b1) $display("FAIL nobypass_state got=%0d/%b exp=1/1", credit_cnt, locked); else passed++;
        credit_in = 1'b0;
        #1;
        total++; if (pop !== 7'b0000010) $display("FAIL tail5_pop got=%b exp=0000010", pop); else passed++;
        step();
        total++; if (out_flit !== 32'hC000_0005 || locked !== 1'b0 || credit_cnt !== 3'd0) $display("FAIL tail5_state got=%h/%b/%0d exp=c0000005/0/0", out_flit, locked, credit_cnt); else passed++;

        clear_inputs();
        credit_in = 1'b1;
        for (int k = 0; k < 4; k++) step();
        credit_in = 1'b0;
        total++; if (credit_cnt !== 3'd4) $display("FAIL pkt_refill got=%0d exp=4", credit_cnt); else passed++;
    endtask

    // 6-flit packet on inport 1 with 4 credits and no returns.
    task automatic test_credit_stall();
        logic [0:FW-1] f [6];
        f[0] = 32'h4000_0011; f[1] = 32'h8000_0012; f[2] = 32'h8000_0013;
        f[3] = 32'h8000_0014; f[4] = 32'h8000_0015; f[5] = 32'hC000_0016;
        clear_inputs();
        isNew = 1'b1; firstPriority = 3'd1;
        for (int k = 0; k < 4; k++) begin
            put_flit(1, f[k]);
            #1;
            total++; if (pop !== 7'b0100000) $display("FAIL stall_pop%0d got=%b exp=0100000", k, pop); else passed++;
            step();
            total++; if (out_flit !== f[k] || credit_cnt !== 3'(3 - k)) $display("FAIL stall_out%0d got=%h/%0d exp=%h/%0d", k, out_flit, credit_cnt, f[k], 3 - k); else passed++;
        end
        put_flit(1, f[4]);
        #1;
        total++; if (pop !== 7'b0) $display("FAIL stall_blocked_pop got=%b exp=0", pop); else passed++;
        step();
        total++; if (out_valid !== 1'b0 || locked !== 1'b1) $display("FAIL stall_blocked got=%b/%b exp=0/1", out_valid, locked); else passed++;
        credit_in = 1'b1;
        #1;
        total++; if (pop !== 7'b0) $display("FAIL stall_credit_cycle_pop got=%b exp=0", pop); else passed++;
        step();
        credit_in = 1'b0;
        #1;
        total++; if (pop !== 7'b0100000) $display("FAIL stall_resume_pop got=%b exp=0100000", pop); else passed++;
        step();
        total++; if (out_valid !== 1'b1 || out_flit !== f[4] || credit_cnt !== 3'd0) $display("FAIL stall_resume got=%b/%h/%0d exp=1/%h/0", out_valid, out_flit, credit_cnt, f[4]); else passed++;
        put_flit(1, f[5]);
        #1;
        total++; if (pop !== 7'b0) $display("FAIL stall_one_only got=%b exp=0", pop); else passed++;
        step();

        flit_valid[1] = 1'b0;
        credit_in = 1'b1;
        step(); step();
        credit_in = 1'b0;
        total++; if (credit_cnt !== 3'd2) $display("FAIL refill2 got=%0d exp=2", credit_cnt); else passed++;

        // Send and credit return together: count unchanged.
        put_flit(1, f[5]);
        credit_in = 1'b1;
        #1;
        total++; if (pop !== 7'b0100000) $display("FAIL simul_pop got=%b exp=0100000", pop); else passed++;
        step();
        total++; if (credit_cnt !== 3'd2 || out_flit !== f[5] || locked !== 1'b0) $display("FAIL simul_state got=%0d/%h/%b exp=2/%h/0", credit_cnt, out_flit, locked, f[5]); else passed++;

        clear_inputs();
        credit_in = 1'b1;
        step(); step();
        total++; if (credit_cnt !== 3'd4) $display("FAIL refill4 got=%0d exp=4", credit_cnt); else passed++;
`ifdef OUTPORT_ALLOC_STATS_EN
        total++; if (credit_err !== 1'b0) $display("FAIL credit_err_early got=%b exp=0", credit_err); else passed++;
`endif
        step();
        credit_in = 1'b0;
        total++; if (credit_cnt !== 3'd4) $display("FAIL saturate got=%0d exp=4", credit_cnt); else passed++;
`ifdef OUTPORT_ALLOC_STATS_EN
        total++; if (credit_err !== 1'b1) $display("FAIL credit_err got=%b exp=1", credit_err); else passed++;
        total++; if (pkt_count !== 16'd3) $display("FAIL pkt_count_stall got=%0d exp=3", pkt_count); else passed++;
`endif
    endtask

    // HEADTAIL on inport 0 then HEAD from inport 6 on the next cycle.
    task automatic test_back_to_back();
        clear_inputs();
        isNew = 1'b1; firstPriority = 3'd0;
        put_flit(0, 32'h0000_00A0);
        #1;
        total++; if (pop !== 7'b1000000) $display("FAIL b2b_ht_pop got=%b exp=1000000", pop); else passed++;
        step();
        total++; if (out_valid !== 1'b1 || out_flit !== 32'h0000_00A0 || locked !== 1'b0) $display("FAIL b2b_ht_out got=%b/%h/%b exp=1/000000a0/0", out_valid, out_flit, locked); else passed++;
`ifdef OUTPORT_ALLOC_STATS_EN
        total++; if (pkt_count !== 16'd4) $display("FAIL b2b_pkt_count got=%0d exp=4", pkt_count); else passed++;
`endif
        flit_valid[0] = 1'b0;
        firstPriority = 3'd6;
        put_flit(6, 32'h4000_0006);
        #1;
        total++; if (pop !== 7'b0000001) $display("FAIL b2b_head_pop got=%b exp=0000001", pop); else passed++;
        step();
        total++; if (out_flit !== 32'h4000_0006 || locked !== 1'b1 || owner !== 3'd6) $display("FAIL b2b_head got=%h/%b/%0d exp=40000006/1/6", out_flit, locked, owner); else passed++;
        put_flit(6, 32'hC000_0006);
        isNew = 1'b0;
        #1;
        total++; if (pop !== 7'b0000001) $display("FAIL b2b_tail_pop got=%b exp=0000001", pop); else passed++;
        step();
        total++; if (locked !== 1'b0 || credit_cnt !== 3'd1) $display("FAIL b2b_tail got=%b/%0d exp=0/1", locked, credit_cnt); else passed++;
`ifdef OUTPORT_ALLOC_STATS_EN
        total++; if (pkt_count !== 16'd5) $display("FAIL b2b_pkt_count2 got=%0d exp=5", pkt_count); else passed++;
`endif
        clear_inputs();
        credit_in = 1'b1;
        step(); step(); step();
        credit_in = 1'b0;
        total++; if (credit_cnt !== 3'd4) $display("FAIL b2b_refill got=%0d exp=4", credit_cnt); else passed++;
    endtask

    task automatic test_boundary();
        clear_inputs();
        isNew = 1'b1; firstPriority = 3'd7;
        for (int i = 0; i < P; i++) put_flit(i, 32'h4000_0100);
        #1;
        total++; if (pop !== 7'b0) $display("FAIL bnd_fp_range got=%b exp=0", pop); else passed++;
        firstPriority = 3'd3;
        flit_valid[3] = 1'b0;
        #1;
        total++; if (pop !== 7'b0) $display("FAIL bnd_invalid got=%b exp=0", pop); else passed++;
        firstPriority = 3'd4;
        put_flit(4, 32'h8000_0104);
        #1;
        total++; if (pop !== 7'b0) $display("FAIL bnd_body_idle got=%b exp=0", pop); else passed++;
        isNew = 1'b0;
        firstPriority = 3'd0;
        #1;
        total++; if (pop !== 7'b0) $display("FAIL bnd_no_isnew got=%b exp=0", pop); else passed++;
        step();
        total++; if (out_valid !== 1'b0 || locked !== 1'b0 || credit_cnt !== 3'd4) $display("FAIL bnd_state got=%b/%b/%0d exp=0/0/4", out_valid, locked, credit_cnt); else passed++;
    endtask

    task automatic test_rst_mid_packet();
        clear_inputs();
        isNew = 1'b1; firstPriority = 3'd3;
        put_flit(3, 32'h4000_0003);
        step();
        total++; if (locked !== 1'b1 || owner !== 3'd3) $display("FAIL mid_lock got=%b/%0d exp=1/3", locked, owner); else passed++;
        put_flit(3, 32'h8000_0003);
        #2;
        rst = 1'b1;
        #1;
        total++; if (locked !== 1'b0 || owner !== 3'd0 || pop !== 7'b0) $display("FAIL mid_rst got=%b/%0d/%b exp=0/0/0", locked, owner, pop); else passed++;
        total++; if (out_valid !== 1'b0 || credit_cnt !== 3'd4) $display("FAIL mid_rst_out got=%b/%0d exp=0/4", out_valid, credit_cnt); else passed++;
        step();
        clear_inputs();
        rst = 1'b0;
        step();
        total++; if (locked !== 1'b0 || out_valid !== 1'b0) $display("FAIL mid_after got=%b/%b exp=0/0", locked, out_valid); else passed++;
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_packet_lock();
        test_credit_stall();
        test_back_to_back();
        test_boundary();
        test_rst_mid_packet();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
